skew_sched: RTL and testbench

- Sequencing controller that feeds operand vectors into the systolic PE array of the dual-mode DNN core.
- Accepts one L-lane vector per handshake and releases lane i after i extra cycles, producing the diagonal wavefront the array needs.
- In bypass mode (dense/FC), all lanes are released aligned.
- Tracks frame boundaries, drains the skew pipeline after the last beat, and pulses done; stalls the whole pipeline on downstream backpressure.

---
 rtl/skew_sched_pkg.sv | 19 +
 rtl/skew_sched_if.sv | 26 ++
 rtl/skew_sched_delay_en.sv | 44 ++++
 rtl/skew_sched.sv | 108 ++++++++++
 tb/tb_skew_sched.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/skew_sched_pkg.sv
// Shared types and constants for the skew scheduler that feeds the systolic PE array.
package skew_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic MODE_BYPASS = 1'b0;
    localparam logic MODE_SKEW   = 1'b1;

    // Advances spent in DRAIN beyond the first: the deepest lane must empty in skew mode.
    function automatic int unsigned drain_len(input logic mode, input int unsigned lanes);
        return (mode == MODE_SKEW) ? (lanes - 32'd1) : 32'd0;
    endfunction

endpackage

// File: rtl/skew_sched_if.sv
// Vector handshake bundle between the operand source, the skew scheduler and the PE array.
interface skew_sched_if #(
    parameter int B = 8,
    parameter int L = 4
);
    logic           mode;
    logic           in_valid;
    logic           in_ready;
    logic           in_last;
    logic [L*B-1:0] in_data;
    logic           out_ready;
    logic [L-1:0]   out_valid;
    logic [L*B-1:0] out_data;
    logic           busy;
    logic           done;

    modport master (
        output mode, in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  mode, in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/skew_sched_delay_en.sv
// N-stage data+valid shift register with advance enable and flush; exposes first and last stage.
module delay_en #(
    parameter int B = 8,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [B-1:0] d_i,
    input  logic         v_i,
    output logic [B-1:0] head_d_o,
    output logic         head_v_o,
    output logic [B-1:0] tail_d_o,
    output logic         tail_v_o
);

    logic [N-1:0][B-1:0] data_q;
    logic [N-1:0]        vld_q;

    // Shift chain; flush has priority over an advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= '0;
        end else if (clr_i) begin
            data_q <= '0;
            vld_q  <= '0;
        end else if (en_i) begin
            data_q[0] <= d_i;
            vld_q[0]  <= v_i;
            for (int k = 1; k < N; k++) begin
                data_q[k] <= data_q[k-1];
                vld_q[k]  <= vld_q[k-1];
            end
        end
    end

    assign head_d_o = data_q[0];
    assign head_v_o = vld_q[0];
    assign tail_d_o = data_q[N-1];
    assign tail_v_o = vld_q[N-1];

endmodule

// File: rtl/skew_sched.sv
// Skew scheduler: releases lane i of each vector i advances late (skew) or all aligned (bypass),
// drains the wavefront after the last beat and pulses done.
module skew_sched
    import skew_sched_pkg::*;
#(
    parameter int B = 8,
    parameter int L = 4
) (
    input logic         clk,
    input logic         rst_n,
    skew_sched_if.slave bus
);

    localparam int CW = (L > 2) ? $clog2(L) : 1;

    state_e        state_q;
    logic          mode_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic adv_s;
    logic xfer_s;
    logic flush_s;
    logic mode_d;

    logic [L-1:0][B-1:0] head_d_s;
    logic [L-1:0][B-1:0] tail_d_s;
    logic [L-1:0]        head_v_s;
    logic [L-1:0]        tail_v_s;

    assign adv_s    = bus.out_ready;
    assign bus.in_ready = rst_n & bus.out_ready & ((state_q == ST_IDLE) | (state_q == ST_STREAM));
    assign xfer_s   = bus.in_valid & bus.in_ready;
    assign mode_d   = (state_q == ST_IDLE) ? bus.mode : mode_q;
    // Leaving DONE the visible stages are already empty; wipe the hidden ones so a bypass
    // frame cannot leak stale beats into the deep lanes of a following skew frame.
    assign flush_s  = (state_q == ST_DONE);

    // Frame sequencing, drain countdown and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_BYPASS;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_STREAM: begin
                    if (xfer_s) begin
                        mode_q <= mode_d;
                        busy_q <= 1'b1;
                        if (bus.in_last) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= CW'(drain_len(mode_d, unsigned'(L)));
                        end else begin
                            state_q <= ST_STREAM;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (adv_s) begin
                        if (cnt_q == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < L; i++) begin : g_lane
        logic [B-1:0] lane_in_s;
        assign lane_in_s = xfer_s ? bus.in_data[i*B +: B] : {B{1'b0}};

        delay_en #(.B(B), .N(i + 1)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_i     (adv_s),
            .clr_i    (flush_s),
            .d_i      (lane_in_s),
            .v_i      (xfer_s),
            .head_d_o (head_d_s[i]),
            .head_v_o (head_v_s[i]),
            .tail_d_o (tail_d_s[i]),
            .tail_v_o (tail_v_s[i])
        );
    end

    assign bus.out_data  = (mode_q == MODE_SKEW) ? tail_d_s : head_d_s;
    assign bus.out_valid = (mode_q == MODE_SKEW) ? tail_v_s : head_v_s;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_skew_sched.sv
// Randomised scoreboard bench for skew_sched: a frame-level model predicts, per lane, the
// advance count at which each operand must appear; a negedge monitor checks every cycle.
module tb_skew_sched;

    localparam int B = 8;
    localparam int L = 4;
    localparam int P_IDLE = 0, P_STREAM = 1, P_DRAIN = 2, P_DONE = 3;
    localparam int BUDGET = 400;

    typedef struct {
        int         due;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    skew_sched_if #(.B(B), .L(L)) bus ();

    skew_sched #(.B(B), .L(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        lq [L][$];
    logic [31:0] fixed_q [$];
    int          phase = P_IDLE;
    int          adv_cnt = 0;
    int          target = 0;
    logic        m_mode = 1'b0;
    logic        m_xfer = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: frame-level bookkeeping in units of array advances.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            phase  = P_IDLE;
            m_xfer = 1'b0;
            for (int i = 0; i < L; i++) lq[i].delete();
        end else begin
            logic adv, x;
            adv = bus.out_ready;
            x   = bus.in_valid && bus.out_ready && (phase == P_IDLE || phase == P_STREAM);
            m_xfer = x;
            if (adv) adv_cnt++;
            if (x) begin
                if (phase == P_IDLE) m_mode = bus.mode;
                for (int i = 0; i < L; i++)
                    lq[i].push_back('{due: adv_cnt + (m_mode ? i : 0), d: bus.in_data[i*B +: B]});
                if (bus.in_last) begin
                    phase  = P_DRAIN;
                    target = adv_cnt + (m_mode ? L - 1 : 0) + 1;
                end else begin
                    phase = P_STREAM;
                end
            end else if (phase == P_DRAIN && adv && adv_cnt == target) begin
                phase = P_DONE;
            end else if (phase == P_DONE) begin
                phase = P_IDLE;
            end
        end
    end

    // Monitor: compare DUT outputs against the model between clock edges.
    initial forever begin
        @(negedge clk);
        chk("in_ready", {31'd0, bus.in_ready},
            {31'd0, rst_n && bus.out_ready && (phase == P_IDLE || phase == P_STREAM)});
        chk("busy", {31'd0, bus.busy}, {31'd0, phase != P_IDLE});
        chk("done", {31'd0, bus.done}, {31'd0, phase == P_DONE});
        for (int i = 0; i < L; i++) begin
            logic [7:0] lane;
            lane = bus.out_data[i*B +: B];
            if (bus.out_valid[i]) begin
                if (lq[i].size() == 0) begin
                    chk($sformatf("lane%0d_valid", i), {31'd0, bus.out_valid[i]}, 32'd0);
                end else begin
                    chk($sformatf("lane%0d_time", i), adv_cnt, lq[i][0].due);
                    chk($sformatf("lane%0d_data", i), {24'd0, lane}, {24'd0, lq[i][0].d});
                    if (bus.out_ready && rst_n) void'(lq[i].pop_front());
                end
            end else begin
                chk($sformatf("lane%0d_bubble_data", i), {24'd0, lane}, 32'd0);
                if (lq[i].size() != 0)
                    chk($sformatf("lane%0d_valid", i), {31'd0, bus.out_valid[i]},
                        {31'd0, lq[i][0].due <= adv_cnt});
            end
        end
    end

    function automatic logic rnd_ready(input int stall_pct);
        return ($urandom_range(99) >= stall_pct);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input logic fm, input int n, input int gap, input int stall_pct,
                             input int hold_at, input int rst_after);
        int   guard = 0;
        int   rcnt = 0;
        logic got;
        logic [31:0] data;
        for (int j = 0; j < n; j++) begin
            data = (fixed_q.size() != 0) ? fixed_q.pop_front() : $urandom;
            bus.in_data = data;
            bus.in_last = (j == n - 1);
            bus.mode    = (j == 0) ? fm : 1'($urandom_range(1));
            bus.in_valid = 1'b1;
            if (j == hold_at) begin
                bus.out_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
            end
            got = 1'b0;
            while (!got && guard < BUDGET) begin
                bus.out_ready = rnd_ready(stall_pct);
                @(posedge clk); #1;
                guard++;
                got = m_xfer;
            end
            bus.in_valid = 1'b0;
            repeat (gap) begin
                bus.out_ready = rnd_ready(stall_pct);
                @(posedge clk); #1;
            end
        end
        while (phase != P_IDLE && guard < BUDGET) begin
            if (rcnt == rst_after) do_reset();
            bus.out_ready = rnd_ready(stall_pct);
            @(posedge clk); #1;
            guard++;
            rcnt++;
        end
        chk("frame_within_budget", {31'd0, guard < BUDGET}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.in_data = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        fixed_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        run_frame(1'b1, 3, 0, 0, -1, -1);
        fixed_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        run_frame(1'b0, 3, 0, 0, -1, -1);
        fixed_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        run_frame(1'b1, 3, 0, 0, 1, -1);
        run_frame(1'b1, 3, 1, 0, -1, -1);
        run_frame(1'b1, 3, 0, 0, -1, 1);
        fixed_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        run_frame(1'b1, 3, 0, 0, -1, -1);
        fixed_q = '{32'hDDCCBBAA};
        run_frame(1'b1, 1, 0, 0, -1, -1);
        for (int f = 0; f < 30; f++)
            run_frame(1'($urandom_range(1)), $urandom_range(6, 1), $urandom_range(2),
                      $urandom_range(40), -1, -1);

        bus.out_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("queues_empty", lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
